inv_shift_rows_serial: RTL
==========================

// Module: inv_shift_rows_serial
// PURPOSE
//   Byte-serial AES InvShiftRows stage for the decrypt datapath; the inverse of shift_rows.
//   Accepts a 16-byte state as a valid/ready byte stream and buffers the block.
//   Emits the inverse-permuted 16 bytes as a valid/ready byte stream.
//   With BANKS=2, input of the next block overlaps output of the current one.
// PARAMETERS
//   BANKS     2   block buffers: 1 = no fill/drain overlap; 2 = ping-pong, sustained 1 byte/clk
// PORTS
//   clk        in   1  single clock, all logic on posedge
//   rst_n      in   1  synchronous, active-low reset
//   in_valid   in   1  input byte valid
//   in_ready   out  1  block can accept a byte
//   in_data    in   8  state byte; stream order = byte 0 first (byte 0 = [127:120] of 128b word)
//   in_last    in   1  marks byte 15 of a block
//   out_valid  out  1  output byte valid
//   out_ready  in   1  downstream accepts byte
//   out_data   out  8  permuted byte; 8'h00 whenever out_valid=0
//   out_last   out  1  high with output byte 15
//   err        out  1  sticky framing error
// BEHAVIOUR
//   - Byte index k = 4*c + r (column-major AES state). InvShiftRows: out[4c+r] = in[4*((c-r) mod 4)+r].
//   - Reset (rst_n=0 at posedge): wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, all full flags=0, err=0.
//   - While rst_n=0: in_ready, out_valid and out_last are forced 0.
//   - Write side: in_ready = ~full[wr_bank]. Accept means in_valid & in_ready.
//     - On accept, bank[wr_bank][wr_cnt] <= in_data and wr_cnt increments.
//     - Accept with wr_cnt=15: full[wr_bank]<=1, wr_bank toggles (BANKS=2), wr_cnt<=0.
//   - Read side: out_valid = full[rd_bank]; out_data = bank[rd_bank][perm(rd_cnt)]; out_last = (rd_cnt==15).
//     - Accept means out_valid & out_ready; rd_cnt increments on accept.
//     - Accept with rd_cnt=15: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
//   - Latency: out_valid rises the cycle after byte 15 is accepted (registered full flag).
//     Byte 0 of the output is the first byte presented.
//   - Backpressure: out_data/out_last hold stable while out_valid & ~out_ready.
//   - Both banks full: in_ready=0 until the read side finishes draining a bank.
//   - Fill-complete and drain-complete in the same cycle (different banks): both flag updates take effect.
//     The write side can never set a bank that is already full.
//   - Framing, early last: in_last=1 on accept with wr_cnt<15 -> partial block discarded, wr_cnt<=0, err<=1.
//   - Framing, missing last: in_last=0 on accept with wr_cnt=15 -> block completes normally, err<=1.
//   - err clears only on reset.
//   - Reset mid-block: partial input and undrained output are discarded; no byte is emitted after reset.
//   - BANKS=1: wr_bank and rd_bank stay 0; input stalls until the block has fully drained.
// CONFIGURATION
//   ISR_FWD_MODE_EN defined: adds input port fwd (1 bit). fwd is sampled on the accept of byte 0
//     and stored per bank.
//     - fwd=1: bank emits forward ShiftRows, out[4c+r] = in[4*((c+r) mod 4)+r].
//     - fwd=0: bank emits InvShiftRows.
//   ISR_FWD_MODE_EN undefined: no fwd port; always InvShiftRows.
// TESTING
//   1) Stream d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, out_ready=1
//      -> out d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30; out_last on the 16th byte; err=0.
//   2) Blocks 49db873b453953897f02d2f177de961a then acc1d6b8efb55a7b1323cfdf457311b5, back-to-back, BANKS=2
//      -> 49ded28945db96f17f39871a7702533b and ac73cf7befc111df13b5d6b545235ab8.
//      in_ready stays 1 throughout; 32 output bytes in 33 cycles.
//   3) out_ready=0 while two blocks are sent -> in_ready=0 after 32 bytes.
//      out_data is held stable while stalled.
//      Releasing out_ready drains both blocks in order.
//   4) in_last on byte 5 -> err=1, nothing emitted.
//      The following full block is output correctly.
//   5) Assert rst_n=0 after 9 input bytes, then send one full block
//      -> all outputs 0 during reset; only the new block is emitted, correctly permuted.
//   6) ISR_FWD_MODE_EN, fwd=1, input d42711aee0bf98f1b8b45de51e415230 -> out d4bf5d30e0b452aeb84111f11e2798e5.

Source files
------------

// File: rtl/inv_shift_rows_serial.sv
// inv_shift_rows_serial: byte-serial AES InvShiftRows stage.
// A 16-byte state arrives as a valid/ready byte stream (byte 0 first), is
// buffered in one of BANKS block buffers, and leaves as a valid/ready byte
// stream in InvShiftRows order. BANKS=2 ping-pongs so fill and drain overlap.
// Optional feature macro: ISR_FWD_MODE_EN adds a per-block fwd input that
// selects forward ShiftRows instead of InvShiftRows for that block.
module inv_shift_rows_serial #(
    parameter int unsigned BANKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
`ifdef ISR_FWD_MODE_EN
    input  logic       fwd,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       err
);

    localparam int unsigned NB = (BANKS == 2) ? 2 : 1;

    // Source byte index for output byte k = 4c+r (column-major state).
    // Inverse: column (c-r) mod 4; forward: column (c+r) mod 4.
    function automatic logic [3:0] src_idx(input logic [3:0] k, input logic fwd_m);
        logic [1:0] col;
        col = fwd_m ? (k[3:2] + k[1:0]) : (k[3:2] - k[1:0]);
        return {col, k[1:0]};
    endfunction

    logic [7:0]    mem_q [NB][16];
    logic [7:0]    mem_d [NB][16];
    logic [3:0]    wr_cnt_q, wr_cnt_d;
    logic [3:0]    rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [NB-1:0] full_q, full_d;
    logic          err_q, err_d;
    logic          in_acc, out_acc;
    logic          bank_fwd;
    logic [3:0]    rd_src;

`ifdef ISR_FWD_MODE_EN
    logic [NB-1:0] fwd_q, fwd_d;
    assign bank_fwd = fwd_q[rd_bank_q];
`else
    assign bank_fwd = 1'b0;
`endif

    // Handshake and output datapath; everything visible is forced idle in reset.
    always_comb begin
        in_ready  = rst_n & ~full_q[wr_bank_q];
        out_valid = rst_n & full_q[rd_bank_q];
        in_acc    = in_valid & in_ready;
        out_acc   = out_valid & out_ready;
        rd_src    = src_idx(rd_cnt_q, bank_fwd);
        out_data  = out_valid ? mem_q[rd_bank_q][rd_src] : 8'h00;
        out_last  = out_valid & (rd_cnt_q == 4'd15);
        err       = err_q;
    end

    // Next-state for write/read pointers, bank flags, stored data and error.
    always_comb begin
        mem_d     = mem_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        err_d     = err_q;
`ifdef ISR_FWD_MODE_EN
        fwd_d     = fwd_q;
        if (in_acc && (wr_cnt_q == 4'd0)) begin
            fwd_d[wr_bank_q] = fwd;
        end
`endif
        if (in_acc) begin
            mem_d[wr_bank_q][wr_cnt_q] = in_data;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = (NB == 2) ? ~wr_bank_q : 1'b0;
                wr_cnt_d          = 4'd0;
                if (!in_last) begin
                    err_d = 1'b1;
                end
            end else if (in_last) begin
                // Early last: drop the partial block, restart at byte 0.
                wr_cnt_d = 4'd0;
                err_d    = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 4'd1;
            end
        end
        // Drain side only ever clears a bank the write side is not filling.
        if (out_acc) begin
            if (rd_cnt_q == 4'd15) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = (NB == 2) ? ~rd_bank_q : 1'b0;
                rd_cnt_d          = 4'd0;
            end else begin
                rd_cnt_d = rd_cnt_q + 4'd1;
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q  <= 4'd0;
            rd_cnt_q  <= 4'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            err_q     <= 1'b0;
`ifdef ISR_FWD_MODE_EN
            fwd_q     <= '0;
`endif
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            err_q     <= err_d;
`ifdef ISR_FWD_MODE_EN
            fwd_q     <= fwd_d;
`endif
        end
    end

    // Block buffer storage; contents are don't-care until a bank is marked full.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
